// File: rtl/pkt_reader_pkg.sv
// Shared definitions for the packet reader: FSM state encoding, the layout
// of the FIFO word and the default output-stall timeout.
package pkt_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a header word
    HDR  = 2'd1,  // header held in the output register
    BODY = 2'd2,  // forwarding payload bytes
    PAR  = 2'd3   // waiting for / forwarding the parity byte
  } state_t;

  // FIFO word: [HDR_BIT] marks a header, [HDR_BIT-1:0] is the byte.
  localparam int HDR_BIT = 8;

  // Payload length field inside the header byte.
  localparam int LEN_HI = 7;
  localparam int LEN_LO = 2;
  localparam int LEN_W  = LEN_HI - LEN_LO + 1;

  // Output stall cycles tolerated before the packet is dropped.
  localparam int DEFAULT_TIMEOUT = 30;

endpackage

// File: rtl/pkt_reader_stall_timer.sv
// Output-stall timer for the packet reader.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   count_en  - a stall cycle (data offered, not accepted)
//   clear     - restart from zero; wins over count_en
//   expired   - this cycle is stall number TIMEOUT if it stalls again
module stall_timer
  import pkt_reader_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + CW'(1);
    end
  end

  // Expired one count early so the owner can still let a transfer in the
  // same cycle win over the timeout.
  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pkt_reader.sv
// Packet reader: pulls header/payload/parity words out of a FIFO with a
// one-cycle read latency, forwards them to a valid/ready output port,
// checks the trailing parity byte and drops a packet whose output stalls.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   fifo_empty      - FIFO has no words
//   fifo_re         - FIFO read enable (data returns the following cycle)
//   fifo_dout       - FIFO word, bit DW = header marker
//   out_data/out_valid/out_ready/out_last - output port, last = parity byte
//   pkt_done        - pulse on the parity-byte transfer
//   parity_err      - pulse with pkt_done on parity mismatch
//   frame_err       - pulse on a header-marker violation
//   soft_rst        - pulse to the FIFO when the output stall times out
module pkt_reader
  import pkt_reader_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  output logic          fifo_re,
  input  logic [DW:0]   fifo_dout,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          pkt_done,
  output logic          parity_err,
  output logic          frame_err,
  output logic          soft_rst
);

  localparam logic [LEN_W:0] REM_ONE = (LEN_W + 1)'(1);
  localparam logic [LEN_W:0] REM_TWO = (LEN_W + 1)'(2);

  state_t         state;
  logic [LEN_W:0] remain;     // bytes still to forward before the parity byte, plus one
  logic [DW-1:0]  parity;
  logic           in_flight;  // fifo_dout carries a returned word this cycle
  logic           run;        // holds reads off until the first edge after reset
  logic           xfer;
  logic           is_hdr;
  logic           expired;
  logic           timeout;

  assign xfer    = out_valid & out_ready;
  assign is_hdr  = fifo_dout[HDR_BIT];
  assign timeout = expired & out_valid & ~out_ready;

  // A returned word always finds the output register empty: a read is only
  // issued when the register is empty or emptying, so no skid slot is needed.
  assign fifo_re    = run & ~fifo_empty & ~in_flight & (~out_valid | out_ready);
  assign soft_rst   = timeout;
  assign pkt_done   = xfer & (state == PAR);
  assign parity_err = pkt_done & (out_data != parity);
  assign frame_err  = in_flight & ((state == IDLE) ? ~is_hdr : is_hdr);

  stall_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_stall_timer (
    .clk      (clk),
    .rst      (rst),
    .count_en (out_valid & ~out_ready),
    .clear    (xfer | timeout),
    .expired  (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remain    <= '0;
      parity    <= '0;
      in_flight <= 1'b0;
      run       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      run       <= 1'b1;
      in_flight <= fifo_re;
      if (timeout) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        in_flight <= 1'b0;
      end else if (in_flight) begin
        if (is_hdr) begin
          // A marker word always restarts framing, even mid-packet.
          out_data  <= fifo_dout[DW-1:0];
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          parity    <= fifo_dout[DW-1:0];
          remain    <= {1'b0, fifo_dout[LEN_HI:LEN_LO]} + REM_ONE;
          state     <= HDR;
        end else if (state != IDLE) begin
          out_data  <= fifo_dout[DW-1:0];
          out_valid <= 1'b1;
          out_last  <= (state == PAR);
        end
      end else if (xfer) begin
        out_valid <= 1'b0;
        case (state)
          HDR:  state <= (remain == REM_ONE) ? PAR : BODY;
          BODY: begin
            parity <= parity ^ out_data;
            remain <= remain - REM_ONE;
            if (remain == REM_TWO) state <= PAR;
          end
          PAR: begin
            out_last <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pkt_reader.sv
module tb_pkt_reader;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       done;
    logic       perr;
  } xfer_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic       out_ready = 1'b0;
  logic [8:0] fifo_dout = '0;
  logic       fifo_re, out_valid, out_last, pkt_done, parity_err, frame_err, soft_rst;
  logic [7:0] out_data;

  xfer_t      exp_q[$];
  xfer_t      obs_q[$];
  logic [8:0] fifo_q[$];

  int errors = 0;
  int checks = 0;
  int n_frame, n_soft, n_stray;

  pkt_reader #(
    .TIMEOUT (30),
    .DW      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .fifo_dout  (fifo_dout),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .soft_rst   (soft_rst)
  );

  always #5 clk = ~clk;

  // FIFO with one-cycle read latency; soft_rst flushes it.
  initial begin : fifo_model
    logic re_s, sr_s;
    forever begin
      @(negedge clk);
      re_s = fifo_re;
      sr_s = soft_rst;
      @(posedge clk);
      #1;
      if (sr_s) fifo_q.delete();
      else if (re_s && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Queue one packet into the FIFO; optionally push its expected transfers.
  task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] flip, input bit chk);
    logic [7:0] p, b;
    int len;
    len = int'(hdr[7:2]);
    p = hdr;
    fifo_q.push_back({1'b1, hdr});
    if (chk) exp_q.push_back({hdr, 3'b000});
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      p = p ^ b;
      fifo_q.push_back({1'b0, b});
      if (chk) exp_q.push_back({b, 3'b000});
    end
    fifo_q.push_back({1'b0, p ^ flip});
    if (chk) exp_q.push_back({p ^ flip, 1'b1, 1'b1, (flip != 8'h00)});
  endtask

  // Record transfers and pulses for a fixed number of cycles.
  task automatic collect(input int cycles);
    n_frame = 0;
    n_soft  = 0;
    n_stray = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) obs_q.push_back({out_data, out_last, pkt_done, parity_err});
      else if (pkt_done || parity_err) n_stray++;
      if (frame_err) n_frame++;
      if (soft_rst) n_soft++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({fifo_re, out_valid, out_data, out_last, pkt_done, parity_err, frame_err, soft_rst} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {fifo_re, out_valid, out_data, out_last, pkt_done, parity_err, frame_err, soft_rst});
    end
  endtask

  task automatic test_len0();
    xfer_t e, o;
    exp_q.delete();
    obs_q.delete();
    out_ready = 1'b1;
    push_pkt(8'h01, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_re !== 1'b0) begin
      errors++;
      $display("FAIL release_re: got fifo_re=%b required 0 before first edge", fifo_re);
    end
    collect(20);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL len0_count: got %0d transfers required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL len0_xfer: got %h/%b/%b/%b required %h/%b/%b/%b",
                 o.data, o.last, o.done, o.perr, e.data, e.last, e.done, e.perr);
      end
    end
    checks++;
    if (n_stray != 0 || n_frame != 0) begin
      errors++;
      $display("FAIL len0_pulses: got stray=%0d frame=%0d required 0/0", n_stray, n_frame);
    end
  endtask

  task automatic test_packet(input logic [7:0] flip, input string tag);
    xfer_t e, o;
    exp_q.delete();
    obs_q.delete();
    out_ready = 1'b1;
    push_pkt(8'h39, flip, 1'b1);
    collect(60);
    checks++;
    if (obs_q.size() != 16 || exp_q.size() != 16) begin
      errors++;
      $display("FAIL %s_count: got %0d transfers required 16", tag, obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s_xfer: got %h/%b/%b/%b required %h/%b/%b/%b", tag,
                 o.data, o.last, o.done, o.perr, e.data, e.last, e.done, e.perr);
      end
    end
    checks++;
    if (n_stray != 0 || n_frame != 0 || n_soft != 0) begin
      errors++;
      $display("FAIL %s_pulses: got stray=%0d frame=%0d soft=%0d required 0/0/0",
               tag, n_stray, n_frame, n_soft);
    end
  endtask

  task automatic test_frame();
    xfer_t e, o;
    logic [7:0] b;
    exp_q.delete();
    obs_q.delete();
    out_ready = 1'b1;
    fifo_q.push_back({1'b0, 8'hAA});        // stray word while idle: discarded
    fifo_q.push_back({1'b1, 8'h39});
    exp_q.push_back({8'h39, 3'b000});
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      fifo_q.push_back({1'b0, b});
      exp_q.push_back({b, 3'b000});
    end
    push_pkt(8'h05, 8'h00, 1'b1);           // marker as 5th payload byte
    collect(40);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL frame_count: got %0d transfers required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL frame_xfer: got %h/%b/%b/%b required %h/%b/%b/%b",
                 o.data, o.last, o.done, o.perr, e.data, e.last, e.done, e.perr);
      end
    end
    checks++;
    if (n_frame != 2 || n_stray != 0) begin
      errors++;
      $display("FAIL frame_pulses: got frame=%0d stray=%0d required 2/0", n_frame, n_stray);
    end
  endtask

  task automatic test_timeout();
    xfer_t e, o;
    int stall, soft_at, unstable;
    exp_q.delete();
    obs_q.delete();
    out_ready = 1'b0;
    stall = 0;
    soft_at = -1;
    unstable = 0;
    fifo_q.push_back({1'b1, 8'h39});
    for (int i = 0; i < 3; i++) fifo_q.push_back({1'b0, 8'(i + 1)});
    for (int c = 0; c < 80 && soft_at < 0; c++) begin
      @(negedge clk);
      if (out_valid && !out_ready) begin
        stall++;
        if (out_data !== 8'h39 || out_last !== 1'b0) unstable++;
      end
      if (soft_rst) soft_at = stall;
    end
    checks++;
    if (soft_at != 30) begin
      errors++;
      $display("FAIL timeout_cycle: got soft_rst at stall %0d required 30", soft_at);
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d changed cycles required 0", unstable);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || soft_rst !== 1'b0) begin
      errors++;
      $display("FAIL timeout_drop: got valid=%b soft=%b required 0/0", out_valid, soft_rst);
    end
    out_ready = 1'b1;
    push_pkt(8'h09, 8'h00, 1'b1);
    collect(30);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL after_to_count: got %0d transfers required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL after_to_xfer: got %h/%b/%b/%b required %h/%b/%b/%b",
                 o.data, o.last, o.done, o.perr, e.data, e.last, e.done, e.perr);
      end
    end
    checks++;
    if (n_soft != 0 || n_frame != 0) begin
      errors++;
      $display("FAIL after_to_pulses: got soft=%0d frame=%0d required 0/0", n_soft, n_frame);
    end
  endtask

  task automatic test_timeout_race();
    xfer_t e, o;
    int stall;
    exp_q.delete();
    obs_q.delete();
    out_ready = 1'b0;
    stall = 0;
    push_pkt(8'h01, 8'h00, 1'b1);
    for (int c = 0; c < 80 && stall < 29; c++) begin
      @(negedge clk);
      if (out_valid && !out_ready) stall++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    collect(20);
    checks++;
    if (n_soft != 0) begin
      errors++;
      $display("FAIL race_soft: got %0d soft_rst pulses required 0", n_soft);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL race_count: got %0d transfers required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL race_xfer: got %h/%b/%b/%b required %h/%b/%b/%b",
                 o.data, o.last, o.done, o.perr, e.data, e.last, e.done, e.perr);
      end
    end
  endtask

  task automatic test_rst_mid();
    xfer_t e, o;
    exp_q.delete();
    obs_q.delete();
    out_ready = 1'b1;
    push_pkt(8'h39, 8'h00, 1'b0);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({fifo_re, out_valid, out_data, out_last, pkt_done, parity_err, frame_err, soft_rst} !== 15'd0) begin
      errors++;
      $display("FAIL mid_rst_outputs: got %b required all zero",
               {fifo_re, out_valid, out_data, out_last, pkt_done, parity_err, frame_err, soft_rst});
    end
    fifo_q.delete();
    repeat (2) @(negedge clk);
    push_pkt(8'h09, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    collect(30);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mid_rst_count: got %0d transfers required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mid_rst_xfer: got %h/%b/%b/%b required %h/%b/%b/%b",
                 o.data, o.last, o.done, o.perr, e.data, e.last, e.done, e.perr);
      end
    end
    checks++;
    if (n_frame != 0 || n_stray != 0) begin
      errors++;
      $display("FAIL mid_rst_pulses: got frame=%0d stray=%0d required 0/0", n_frame, n_stray);
    end
  endtask

  initial begin
    test_reset();
    test_len0();
    test_packet(8'h00, "good");
    test_packet(8'h01, "badpar");
    test_frame();
    test_timeout();
    test_timeout_race();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_reader.md
PKT_READER -- requirements
Module: pkt_reader

Interface
REQ-001 Parameter TIMEOUT, default 30: output stall cycles before packet drop.
REQ-002 Parameter DW, default 8: payload byte width; the FIFO word is DW+1 bits.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 fifo_empty  in  1  FIFO holds no words.
REQ-006 fifo_re  out  1  FIFO read enable; fifo_dout is valid on the cycle after fifo_re is sampled high.
REQ-007 fifo_dout  in  9  FIFO word; bit 8 = header marker, bits 7:0 = byte.
REQ-008 out_data  out  8  byte to the output port.
REQ-009 out_valid  out  1  out_data valid.
REQ-010 out_ready  in  1  output port accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-011 out_last  out  1  high with the parity byte.
REQ-012 pkt_done  out  1  one-cycle pulse on the parity-byte transfer.
REQ-013 parity_err  out  1  one-cycle pulse with pkt_done when parity mismatches.
REQ-014 frame_err  out  1  one-cycle pulse on a header-marker violation.
REQ-015 soft_rst  out  1  one-cycle pulse to the FIFO on timeout.

Function
REQ-016 The FSM SHALL have states IDLE, HDR, BODY and PAR.
REQ-017 At most one FIFO read SHALL be in flight.
REQ-018 fifo_re SHALL assert only when: fifo_empty=0; no read is in flight; and the output register is empty or transferring this cycle.
REQ-019 The returned word SHALL load the output register and set out_valid in the cycle it arrives.
- Peak throughput: one byte per 2 cycles.
REQ-020 IDLE: a returned word with bit8=1 is the header.
- Remaining count = header[7:2]+1.
- Running parity = header byte.
- Header is forwarded; next state HDR->BODY, or PAR if length is 0.
REQ-021 IDLE: a returned word with bit8=0 SHALL be discarded, not forwarded, and pulse frame_err.
REQ-022 BODY: each payload transfer SHALL XOR its byte into the parity and decrement the remaining count.
- Count reaching 1 moves the FSM to PAR.
REQ-023 PAR: the parity byte SHALL be forwarded with out_last=1.
- On its transfer: pkt_done pulses; parity_err pulses if byte != running parity; FSM returns to IDLE.
REQ-024 A word with bit8=1 arriving in BODY or PAR SHALL pulse frame_err, abandon the current packet, and be processed as a new header.
REQ-025 The stall counter SHALL increment each cycle with out_valid=1 and out_ready=0, and clear on any transfer.
REQ-026 When the stall counter reaches TIMEOUT, the block SHALL:
- pulse soft_rst;
- clear out_valid and any in-flight read;
- return to IDLE;
- issue no pkt_done.
REQ-027 If a transfer coincides with the timeout cycle, the transfer SHALL win and soft_rst SHALL NOT pulse.
REQ-028 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-029 rst SHALL force all of the following within the same cycle, including mid-packet:
- state=IDLE;
- fifo_re=0, out_valid=0, out_data=0, out_last=0;
- pkt_done=0, parity_err=0, frame_err=0, soft_rst=0;
- stall counter=0, parity=0, in-flight flag=0.
REQ-030 The first fifo_re after reset release SHALL occur no earlier than the first rising edge after release.

Structure
REQ-031 Package pkt_reader_pkg SHALL hold:
- the state enum;
- the header-marker bit index (8);
- the length field position (7:2);
- the default TIMEOUT.
REQ-032 The stall counter SHALL be a sub-module, stall_timer, with ports clk, rst, count_en, clear and expired.

Verification
REQ-033 Header 0x39 (length 14, address 01), 14 payload bytes, correct parity, out_ready=1 throughout -> 16 transfers; out_last and pkt_done on transfer 16; parity_err=0.
REQ-034 Same packet with parity byte XOR 0x01 -> 16 transfers; parity_err and pkt_done pulse together.
REQ-035 Header 0x01 (length 0), parity 0x01 -> 2 transfers; pkt_done with no parity_err.
REQ-036 out_ready held 0 after the header -> soft_rst pulses on stall cycle 30; out_valid drops; the next header word is accepted normally.
REQ-037 A bit8=1 word as the 5th payload byte -> frame_err pulse; that word is forwarded as a new header.
REQ-038 rst asserted mid-BODY -> all outputs 0 that cycle; a fresh packet after release completes with no error.
